// File: rtl/tmds_gen.sv
// TMDS 8b/10b encoder for one DVI/HDMI colour channel: transition minimisation,
// running-disparity balancing and control tokens. Define TMDS_GEN_PIPELINE_EN for a 2-cycle variant.
module tmds_gen (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic [1:0] i_control_data,
    input  logic       i_blanking,
    output logic [9:0] o_encoded
);

    // Stage 1: transition-minimised word q_m and its ones count
    logic [3:0] n1d;
    logic       xnor_mode;
    logic [8:0] qm_s1;
    logic [3:0] n1q_s1;

    always_comb begin
        n1d = '0;
        for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, i_data[i]};
        xnor_mode = (n1d > 4'd4) || ((n1d == 4'd4) && !i_data[0]);
        qm_s1     = '0;
        qm_s1[0]  = i_data[0];
        for (int i = 1; i < 8; i++)
            qm_s1[i] = xnor_mode ? ~(qm_s1[i-1] ^ i_data[i]) : (qm_s1[i-1] ^ i_data[i]);
        qm_s1[8] = ~xnor_mode;
        n1q_s1   = '0;
        for (int i = 0; i < 8; i++) n1q_s1 = n1q_s1 + {3'b000, qm_s1[i]};
    end

    logic [8:0] qm;
    logic [3:0] n1q;
    logic       blank;
    logic [1:0] ctrl;
    logic       s2_vld;

`ifdef TMDS_GEN_PIPELINE_EN
    logic [8:0] qm_q;
    logic [3:0] n1q_q;
    logic       blank_q;
    logic [1:0] ctrl_q;
    logic       vld_q;

    // vld_q keeps stage 2 idle on the first edge after reset so the
    // all-zero pipeline contents never disturb the disparity counter.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            qm_q    <= '0;
            n1q_q   <= '0;
            blank_q <= 1'b0;
            ctrl_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            qm_q    <= qm_s1;
            n1q_q   <= n1q_s1;
            blank_q <= i_blanking;
            ctrl_q  <= i_control_data;
            vld_q   <= 1'b1;
        end
    end

    assign qm     = qm_q;
    assign n1q    = n1q_q;
    assign blank  = blank_q;
    assign ctrl   = ctrl_q;
    assign s2_vld = vld_q;
`else
    assign qm     = qm_s1;
    assign n1q    = n1q_s1;
    assign blank  = i_blanking;
    assign ctrl   = i_control_data;
    assign s2_vld = 1'b1;
`endif

    // Stage 2: DC balancing against the running disparity
    logic signed [5:0] cnt_q, cnt_d, diff;
    logic        [9:0] enc_q, enc_d;

    assign diff = $signed({1'b0, n1q, 1'b0}) - 6'sd8;  // n1q - n0q

    always_comb begin
        enc_d = '0;
        cnt_d = cnt_q;
        if (!s2_vld) begin
            cnt_d = '0;
        end else if (blank) begin
            cnt_d = '0;
            case (ctrl)
                2'b00:   enc_d = 10'b1101010100;
                2'b01:   enc_d = 10'b0010101011;
                2'b10:   enc_d = 10'b0101010100;
                default: enc_d = 10'b1010101011;
            endcase
        end else if ((cnt_q == 6'sd0) || (diff == 6'sd0)) begin
            enc_d = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt_d = qm[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if (cnt_q[5] == diff[5]) begin
            // both non-zero here, so equal signs means the word would
            // push disparity further the same way: invert it
            enc_d = {1'b1, qm[8], ~qm[7:0]};
            cnt_d = cnt_q + (qm[8] ? 6'sd2 : 6'sd0) - diff;
        end else begin
            enc_d = {1'b0, qm[8], qm[7:0]};
            cnt_d = cnt_q - (qm[8] ? 6'sd0 : 6'sd2) + diff;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            enc_q <= '0;
            cnt_q <= '0;
        end else begin
            enc_q <= enc_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_encoded = enc_q;

endmodule

// File: tb/tb_tmds_gen.sv
// Self-checking bench for tmds_gen against a reference encoder written from
// the TMDS rules; latency follows TMDS_GEN_PIPELINE_EN.
module tb_tmds_gen;

`ifdef TMDS_GEN_PIPELINE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [7:0] i_data = '0;
    logic [1:0] i_control_data = '0;
    logic       i_blanking = 1'b0;
    logic [9:0] o_encoded;

    tmds_gen dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_data         (i_data),
        .i_control_data (i_control_data),
        .i_blanking     (i_blanking),
        .o_encoded      (o_encoded)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;
    int mcnt  = 0;
    logic [9:0] pipe_q[$];
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    bit         valid_sym[1024];

    function automatic void model_enc(input logic [7:0] d, input logic [1:0] c, input logic b,
                                      input int cin, output logic [9:0] sym, output int cout);
        int n1, n1q, n0q;
        logic xn;
        logic [8:0] qm;
        sym  = '0;
        cout = cin;
        qm   = '0;
        if (b) begin
            cout = 0;
            case (c)
                2'd0: sym = 10'b1101010100;
                2'd1: sym = 10'b0010101011;
                2'd2: sym = 10'b0101010100;
                default: sym = 10'b1010101011;
            endcase
        end else begin
            n1 = $countones(d);
            xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
            qm[0] = d[0];
            for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
            qm[8] = ~xn;
            n1q = $countones(qm[7:0]);
            n0q = 8 - n1q;
            if (cin == 0 || n1q == n0q) begin
                sym  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                cout = cin + (qm[8] ? (n1q - n0q) : (n0q - n1q));
            end else if ((cin > 0 && n1q > n0q) || (cin < 0 && n0q > n1q)) begin
                sym  = {1'b1, qm[8], ~qm[7:0]};
                cout = cin + (qm[8] ? 2 : 0) + n0q - n1q;
            end else begin
                sym  = {1'b0, qm[8], qm[7:0]};
                cout = cin - (qm[8] ? 0 : 2) + n1q - n0q;
            end
        end
    endfunction

    task automatic reset_model();
        mcnt = 0;
        pipe_q.delete();
        repeat (LAT - 1) pipe_q.push_back(10'h000);
        got_q.delete();
        exp_q.delete();
    endtask

    // drive one cycle; record observed and model-expected output for that edge
    task automatic step(input logic [7:0] d, input logic [1:0] c, input logic b);
        logic [9:0] e;
        int nc;
        i_data = d; i_control_data = c; i_blanking = b;
        model_enc(d, c, b, mcnt, e, nc);
        mcnt = nc;
        pipe_q.push_back(e);
        @(posedge i_clk); #1;
        got_q.push_back(o_encoded);
        exp_q.push_back(pipe_q.pop_front());
    endtask

    task automatic flush();
        repeat (LAT - 1) step(8'h00, 2'd0, 1'b1);
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge i_clk); #1;
            tests++;
            if (o_encoded !== 10'h000) begin
                fails++;
                $display("FAIL reset_hold cyc%0d: got %h want 000", k, o_encoded);
            end
        end
        i_rst = 1'b1;
        reset_model();
    endtask

    task automatic test_disparity();
        logic [9:0] want[3];
        want[0] = 10'h100; want[1] = 10'h0FF; want[2] = 10'h3FF;
        got_q.delete(); exp_q.delete();
        step(8'h00, 2'd0, 1'b0);
        step(8'hFF, 2'd0, 1'b0);
        step(8'h00, 2'd0, 1'b0);
        flush();
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (got_q[k+LAT-1] !== want[k]) begin
                fails++;
                $display("FAIL disparity_seq[%0d]: got %h want %h", k, got_q[k+LAT-1], want[k]);
            end
        end
        for (int k = 0; k < got_q.size(); k++) begin
            tests++;
            if (got_q[k] !== exp_q[k]) begin
                fails++;
                $display("FAIL disparity_model[%0d]: got %h want %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_blank_clear();
        got_q.delete(); exp_q.delete();
        step(8'h00, 2'd0, 1'b1);
        step(8'h00, 2'd0, 1'b0);
        flush();
        tests++;
        if (got_q[LAT] !== 10'h100) begin
            fails++;
            $display("FAIL blank_clear: got %h want 100", got_q[LAT]);
        end
    endtask

    task automatic test_control();
        logic [9:0] want[4];
        want[0] = 10'h354; want[1] = 10'h0AB; want[2] = 10'h154; want[3] = 10'h2AB;
        got_q.delete(); exp_q.delete();
        for (int c = 0; c < 4; c++) step($urandom_range(255), 2'(c), 1'b1);
        flush();
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (got_q[c+LAT-1] !== want[c]) begin
                fails++;
                $display("FAIL ctrl_token[%0d]: got %h want %h", c, got_q[c+LAT-1], want[c]);
            end
        end
    endtask

    task automatic test_alternating();
        int sum;
        logic [9:0] s;
        got_q.delete(); exp_q.delete();
        step(8'h00, 2'd0, 1'b1);
        for (int k = 0; k < 30; k++) step((k % 2) ? 8'h00 : 8'hFF, 2'd0, 1'b0);
        flush();
        sum = 0;
        for (int k = 1; k <= 30; k++) begin
            s = got_q[k+LAT-1];
            sum += 2 * $countones(s) - 10;
            tests++;
            if (!valid_sym[s] || sum > 10 || sum < -10 || s !== exp_q[k+LAT-1]) begin
                fails++;
                $display("FAIL alternating[%0d]: got %h want %h valid=%0d runsum=%0d",
                         k, s, exp_q[k+LAT-1], valid_sym[s], sum);
            end
        end
    endtask

    task automatic test_sweep();
        got_q.delete(); exp_q.delete();
        for (int d = 0; d < 256; d++) begin
            step(8'h00, 2'(d), 1'b1);
            step(8'(d), 2'd0, 1'b0);
        end
        flush();
        for (int k = 0; k < got_q.size(); k++) begin
            tests++;
            if (got_q[k] !== exp_q[k]) begin
                fails++;
                $display("FAIL sweep[%0d]: got %h want %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_random();
        got_q.delete(); exp_q.delete();
        for (int k = 0; k < 300; k++)
            step(8'($urandom), 2'($urandom), ($urandom_range(7) == 0));
        flush();
        for (int k = 0; k < got_q.size(); k++) begin
            tests++;
            if (got_q[k] !== exp_q[k]) begin
                fails++;
                $display("FAIL random[%0d]: got %h want %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_midreset();
        for (int k = 0; k < 6; k++) step(8'($urandom), 2'd0, 1'b0);
        i_rst = 1'b0;
        #2;
        tests++;
        if (o_encoded !== 10'h000) begin
            fails++;
            $display("FAIL midreset_async: got %h want 000", o_encoded);
        end
        @(posedge i_clk); #1;
        tests++;
        if (o_encoded !== 10'h000) begin
            fails++;
            $display("FAIL midreset_hold: got %h want 000", o_encoded);
        end
        i_rst = 1'b1;
        reset_model();
        step(8'h00, 2'd0, 1'b0);
        step(8'hFF, 2'd0, 1'b0);
        flush();
        tests++;
        if (got_q[LAT-1] !== 10'h100 || got_q[LAT] !== 10'h0FF) begin
            fails++;
            $display("FAIL midreset_restart: got %h %h want 100 0ff", got_q[LAT-1], got_q[LAT]);
        end
    endtask

    initial begin
        logic [9:0] s;
        int nc;
        for (int v = 0; v < 1024; v++) valid_sym[v] = 1'b0;
        for (int d = 0; d < 256; d++)
            for (int c = -10; c <= 10; c += 2) begin
                model_enc(8'(d), 2'd0, 1'b0, c, s, nc);
                valid_sym[s] = 1'b1;
            end
        test_reset();
        test_disparity();
        test_blank_clear();
        test_control();
        test_alternating();
        test_sweep();
        test_random();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
